// File: rtl/avsdadc_pkg.sv
// Shared state type, default geometry and helpers for the avsdadc SAR controller.
package avsdadc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StConvert
    } sar_state_e;

    localparam int unsigned DefWidth        = 10;
    localparam int unsigned DefSampleCycles = 2;
    localparam int unsigned DefSettleCycles = 2;

    // Four summed words need two extra bits of headroom.
    function automatic int unsigned acc_width(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/avsdadc_sar_timer.sv
// Phase down-counter: after a load of N, done_o is high during the Nth following cycle.
module avsdadc_sar_timer #(
    parameter int unsigned CntW = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            done_o
);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i - CntW'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/avsdadc_sar_ctrl.sv
// SAR ADC controller: track/hold, MSB-first binary search on the cap-DAC, valid/ready result.
// Define AVSDADC_AVG4_EN to average four back-to-back conversions per accepted start.
module avsdadc_sar_ctrl
    import avsdadc_pkg::*;
#(
    parameter int unsigned WIDTH         = DefWidth,
    parameter int unsigned SAMPLE_CYCLES = DefSampleCycles,
    parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             SAMPLE,
    output logic [WIDTH-1:0] D_TRIAL,
    input  logic             CMP_IN,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    input  logic             ready
);

    localparam int unsigned MaxCyc = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES
                                                                     : SETTLE_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] TopBit = WIDTH'(1) << (WIDTH - 1);

    sar_state_e      state_q;
    logic [IdxW-1:0] bit_idx_q;
    logic [WIDTH-1:0] sar_q;

    logic            timer_load;
    logic            timer_done;
    logic [CntW-1:0] timer_val;

    logic             accept;
    logic             arm;
    logic             sample_end;
    logic             trial_end;
    logic             last_bit;
    logic             next_pass;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] next_mask;
    logic [WIDTH-1:0] kept_word;
    logic [WIDTH-1:0] final_word;

    // A pending result may be retired on the same edge that takes the next start.
    assign accept     = (state_q == StIdle) && start && (!valid || ready);
    // First SAMPLE cycle is a lead-in: outputs go live one edge after acceptance.
    assign arm        = (state_q == StSample) && !busy;
    assign sample_end = (state_q == StSample) && busy && timer_done;
    assign trial_end  = (state_q == StConvert) && timer_done;
    assign last_bit   = (bit_idx_q == '0);
    assign bit_mask   = WIDTH'(1) << bit_idx_q;
    assign next_mask  = bit_mask >> 1;
    assign kept_word  = CMP_IN ? (sar_q | bit_mask) : sar_q;

`ifdef AVSDADC_AVG4_EN
    localparam int unsigned AccW = acc_width(WIDTH);

    logic [1:0]      pass_q;
    logic [AccW-1:0] acc_q;
    logic [AccW-1:0] acc_sum;

    assign acc_sum    = acc_q + AccW'(kept_word);
    assign next_pass  = (pass_q != 2'd3);
    assign final_word = acc_sum[AccW-1:2];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pass_q <= '0;
            acc_q  <= '0;
        end else if (accept) begin
            pass_q <= '0;
            acc_q  <= '0;
        end else if (trial_end && last_bit) begin
            pass_q <= pass_q + 2'd1;
            acc_q  <= acc_sum;
        end
    end
`else
    assign next_pass  = 1'b0;
    assign final_word = kept_word;
`endif

    always_comb begin
        timer_load = 1'b0;
        timer_val  = CntW'(SETTLE_CYCLES);
        if (arm) begin
            timer_load = 1'b1;
            timer_val  = CntW'(SAMPLE_CYCLES);
        end else if (sample_end || (trial_end && !last_bit)) begin
            timer_load = 1'b1;
        end else if (trial_end && next_pass) begin
            timer_load = 1'b1;
            timer_val  = CntW'(SAMPLE_CYCLES);
        end
    end

    avsdadc_sar_timer #(
        .CntW(CntW)
    ) u_timer (
        .clk_i     (CLK),
        .rst_ni    (reset),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .done_o    (timer_done)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_idx_q <= '0;
            sar_q     <= '0;
            busy      <= 1'b0;
            SAMPLE    <= 1'b0;
            D_TRIAL   <= '0;
            result    <= '0;
            valid     <= 1'b0;
        end else begin
            if (valid && ready) begin
                valid <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StSample;
                        sar_q   <= '0;
                    end
                end
                StSample: begin
                    if (arm) begin
                        busy   <= 1'b1;
                        SAMPLE <= 1'b1;
                    end else if (timer_done) begin
                        SAMPLE    <= 1'b0;
                        state_q   <= StConvert;
                        bit_idx_q <= IdxW'(WIDTH - 1);
                        D_TRIAL   <= TopBit;
                    end
                end
                StConvert: begin
                    if (timer_done) begin
                        if (!last_bit) begin
                            sar_q     <= kept_word;
                            bit_idx_q <= bit_idx_q - IdxW'(1);
                            D_TRIAL   <= kept_word | next_mask;
                        end else if (next_pass) begin
                            sar_q   <= '0;
                            D_TRIAL <= '0;
                            SAMPLE  <= 1'b1;
                            state_q <= StSample;
                        end else begin
                            result  <= final_word;
                            valid   <= 1'b1;
                            busy    <= 1'b0;
                            D_TRIAL <= '0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_avsdadc_sar_ctrl.sv
// Randomised bench for avsdadc_sar_ctrl against an ideal-comparator reference model.
module tb_avsdadc_sar_ctrl;

    localparam int W    = 10;
    localparam int SC   = 2;
    localparam int ST   = 2;
    localparam int MAXV = (1 << W) - 1;
    localparam int PER  = SC + W * ST;
`ifdef AVSDADC_AVG4_EN
    localparam int NPASS = 4;
`else
    localparam int NPASS = 1;
`endif
    localparam int LAT = NPASS * PER + 1;

    logic         CLK = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         SAMPLE;
    logic [W-1:0] D_TRIAL;
    logic         CMP_IN;
    logic [W-1:0] result;
    logic         valid;
    logic         ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    avsdadc_sar_ctrl #(
        .WIDTH        (W),
        .SAMPLE_CYCLES(SC),
        .SETTLE_CYCLES(ST)
    ) dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .busy   (busy),
        .SAMPLE (SAMPLE),
        .D_TRIAL(D_TRIAL),
        .CMP_IN (CMP_IN),
        .result (result),
        .valid  (valid),
        .ready  (ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Analog input seen on a given pass (the averaging model drifts by one LSB per pass).
    function automatic int pass_vin(input int vin, input int pass);
`ifdef AVSDADC_AVG4_EN
        return (vin + pass > MAXV) ? MAXV : vin + pass;
`else
        return vin + 0 * pass;
`endif
    endfunction

    function automatic int model_result(input int vin);
        int sum;
        sum = 0;
        for (int p = 0; p < NPASS; p++) sum += pass_vin(vin, p);
        return sum / NPASS;
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_sample"}, SAMPLE, 0);
        check_eq({tag, "_dtrial"}, D_TRIAL, 0);
        check_eq({tag, "_result"}, result, 0);
        check_eq({tag, "_valid"}, valid, 0);
    endtask

    // Called at a falling edge; the following rising edge is the acceptance edge.
    task automatic convert(input int vin, input bit noise, input logic rdy, input int abort_at);
        int vp, pass, o, k, i, exp_d, exp_res;
        exp_res = model_result(vin);
        ready = rdy;
        start = 1'b1;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge CLK);
            if (c == 0) start = 1'b0;
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                check_idle_zero("abort");
                @(negedge CLK);
                reset = 1'b1;
                return;
            end
            if (c == 0) begin
                check_eq("c0_busy", busy, 0);
                check_eq("c0_valid", valid, 0);
                check_eq("c0_sample", SAMPLE, 0);
            end else if (c < LAT) begin
                pass = (c - 1) / PER;
                o    = (c - 1) % PER;
                vp   = pass_vin(vin, pass);
                check_eq($sformatf("busy_c%0d", c), busy, 1);
                check_eq($sformatf("valid_c%0d", c), valid, 0);
                if (o < SC) begin
                    check_eq($sformatf("sample_c%0d", c), SAMPLE, 1);
                    check_eq($sformatf("dtrial_c%0d", c), D_TRIAL, 0);
                end else begin
                    k     = (o - SC) / ST;
                    i     = W - 1 - k;
                    exp_d = ((vp >> (i + 1)) << (i + 1)) | (1 << i);
                    check_eq($sformatf("sample_c%0d", c), SAMPLE, 0);
                    check_eq($sformatf("dtrial_c%0d", c), D_TRIAL, exp_d);
                    if (!noise || ((o - SC) % ST == ST - 1)) CMP_IN = (vp >= int'(D_TRIAL));
                    else CMP_IN = 1'($urandom_range(0, 1));
                end
            end else begin
                check_eq("done_valid", valid, 1);
                check_eq("done_busy", busy, 0);
                check_eq("done_sample", SAMPLE, 0);
                check_eq("done_dtrial", D_TRIAL, 0);
                check_eq($sformatf("result_vin%0h", vin), result, exp_res);
            end
        end
    endtask

    task automatic convert_and_drain(input int vin, input bit noise);
        convert(vin, noise, 1'b1, -1);
        @(negedge CLK);
        check_eq("hs_drop", valid, 0);
    endtask

    initial begin
        int hold_vin;
        reset  = 1'b0;
        start  = 1'b0;
        ready  = 1'b0;
        CMP_IN = 1'b0;
        repeat (3) @(negedge CLK);
        check_idle_zero("reset");
        reset = 1'b1;
        @(negedge CLK);

        convert_and_drain('h2A5, 1'b0);
        convert_and_drain('h000, 1'b0);
        convert_and_drain('h3FF, 1'b0);
        repeat (6) convert_and_drain(int'($urandom_range(0, MAXV)), 1'b1);

        // Result held under backpressure; a start during the hold is ignored.
        hold_vin = 'h1C3;
        convert(hold_vin, 1'b1, 1'b0, -1);
        for (int h = 0; h < 10; h++) begin
            start = (h == 3);
            @(negedge CLK);
            check_eq("hold_valid", valid, 1);
            check_eq("hold_result", result, model_result(hold_vin));
            check_eq("hold_busy", busy, 0);
        end
        start = 1'b0;
        // Handshake and the next start share one edge.
        convert_and_drain(int'($urandom_range(0, MAXV)), 1'b1);

        // Reset during the bit-5 trial, then a clean conversion.
        convert('h2F0, 1'b0, 1'b1, 1 + SC + 4 * ST);
        convert_and_drain('h155, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
